// File: rtl/motoro3_commutator_pkg.sv
// Shared definitions for the 3-phase commutator: FSM encodings, the
// six-step commutation table and the step-period floor.
package motoro3_defs;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RAMP = 2'd1,
      ST_RUN  = 2'd2
   } m3_state_e;

   localparam logic [24:0] MIN_PERIOD = 25'd64;

   // Returns {hi[C,B,A], lo[C,B,A]} for a commutation step.
   function automatic logic [5:0] comm_pattern(input logic [2:0] idx);
      logic [5:0] pat;
      case (idx)
         3'd0:    pat = 6'b001_010;
         3'd1:    pat = 6'b001_100;
         3'd2:    pat = 6'b010_100;
         3'd3:    pat = 6'b010_001;
         3'd4:    pat = 6'b100_001;
         3'd5:    pat = 6'b100_010;
         default: pat = 6'b000_000;
      endcase
      return pat;
   endfunction

endpackage

// File: rtl/motoro3_commutator_pwmgen.sv
// PWM gate generator: free-running period counter with on-time computed
// from the duty percentage and saturated against the driver minimum pulse.
module motoro3_pwmgen
   import motoro3_defs::*;
(
   input  logic        clk,
   input  logic        nRst,
   input  logic        run,
   input  logic        restart,
   input  logic [11:0] pwm_len,
   input  logic [7:0]  pct,
   input  logic [11:0] min_mask,
   output logic        gate
);

   logic [11:0] p_in;
   logic [19:0] prod;
   logic [11:0] raw;
   logic [11:0] on_in;
   logic [11:0] p_q;
   logic [11:0] on_q;
   logic [11:0] cnt_q;

   // Pulses shorter than the mask are dropped; gaps shorter than it go full-on.
   function automatic logic [11:0] on_time_sat(input logic [11:0] p,
                                               input logic [11:0] r,
                                               input logic [11:0] mask);
      logic [11:0] res;
      if (r < mask)
         res = 12'd0;
      else if (({1'b0, r} + {1'b0, mask}) > {1'b0, p})
         res = p;
      else
         res = r;
      return res;
   endfunction

   always_comb begin
      p_in  = (pwm_len < 12'd2) ? 12'd2 : pwm_len;
      prod  = {8'd0, p_in} * {12'd0, pct};
      raw   = prod[19:8];
      on_in = on_time_sat(p_in, raw, min_mask);
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         cnt_q <= 12'd0;
         p_q   <= 12'd2;
         on_q  <= 12'd0;
      end else if (restart) begin
         cnt_q <= 12'd0;
         p_q   <= p_in;
         on_q  <= on_in;
      end else if (!run) begin
         cnt_q <= 12'd0;
         p_q   <= 12'd2;
         on_q  <= 12'd0;
      end else if (cnt_q >= p_q - 12'd1) begin
         cnt_q <= 12'd0;
         p_q   <= p_in;
         on_q  <= on_in;
      end else begin
         cnt_q <= cnt_q + 12'd1;
      end
   end

   assign gate = (cnt_q < on_q);

endmodule

// File: rtl/motoro3_commutator.sv
// Six-step commutation sequencer: soft-start step-rate ramp, dead time at
// every step boundary, PWM-gated high side and steady low side.
module motoro3_commutator
   import motoro3_defs::*;
#(
   parameter logic [24:0] START_PERIOD = 25'd1_666_667,
   parameter int unsigned RAMP_SHIFT   = 4,
   parameter int unsigned DEAD_CLK     = 8
) (
   input  logic        clk,
   input  logic        nRst,
   input  logic        m3c_enable,
   input  logic [24:0] m3r_stepCNT_speedSET,
   input  logic [7:0]  m3r_power_percent,
   input  logic [11:0] m3r_pwmLenWant,
   input  logic [11:0] m3r_pwmMinMask,
   output logic [2:0]  m3c_hiOn,
   output logic [2:0]  m3c_loOn,
   output logic [2:0]  m3c_stepIdx,
   output logic        m3c_stepPulse,
   output logic        m3c_running
);

   localparam logic [7:0] DEAD_LD = 8'(DEAD_CLK);

   m3_state_e   state, state_nx;
   logic [24:0] cur_period, cur_nx;
   logic [24:0] step_cnt;
   logic [24:0] tgt, start_per, ramp_raw, ramp_nx;
   logic [7:0]  dead_cnt, dead_nx;
   logic [2:0]  step_idx, hi_pat, lo_pat;
   logic [2:0]  hi_q, lo_q;
   logic        pulse_q;
   logic        active, wrap, entering, pwm_restart, pwm_gate;

   always_comb begin
      tgt       = (m3r_stepCNT_speedSET < MIN_PERIOD) ? MIN_PERIOD : m3r_stepCNT_speedSET;
      start_per = (START_PERIOD > tgt) ? START_PERIOD : tgt;
      ramp_raw  = cur_period - (cur_period >> RAMP_SHIFT);
      ramp_nx   = (ramp_raw < tgt) ? tgt : ramp_raw;
      active    = (state != ST_IDLE);
      wrap      = active && (step_cnt == cur_period - 25'd1);
      dead_nx   = (dead_cnt != 8'd0) ? dead_cnt - 8'd1 : 8'd0;
      {hi_pat, lo_pat} = comm_pattern(step_idx);
   end

   // The target is only consulted on a wrap, so mid-step changes wait for the boundary.
   always_comb begin
      state_nx = state;
      cur_nx   = cur_period;
      case (state)
         ST_IDLE: begin
            if (m3c_enable) begin
               state_nx = ST_RAMP;
               cur_nx   = start_per;
            end
         end
         ST_RAMP, ST_RUN: begin
            if (!m3c_enable) begin
               state_nx = ST_IDLE;
               cur_nx   = START_PERIOD;
            end else if (wrap) begin
               if ((state == ST_RAMP) || (tgt < cur_period)) begin
                  cur_nx   = ramp_nx;
                  state_nx = (ramp_nx == tgt) ? ST_RUN : ST_RAMP;
               end else begin
                  cur_nx = tgt;
               end
            end
         end
         default: begin
            state_nx = ST_IDLE;
            cur_nx   = START_PERIOD;
         end
      endcase
   end

   assign entering    = (state == ST_IDLE) && (state_nx == ST_RAMP);
   assign pwm_restart = (state_nx == ST_RAMP) && (state != ST_RAMP);

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         state      <= ST_IDLE;
         cur_period <= START_PERIOD;
      end else begin
         state      <= state_nx;
         cur_period <= cur_nx;
      end
   end

   // Dead time lives inside the step: the drive returns once dead_cnt reaches 0.
   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         step_cnt <= 25'd0;
         step_idx <= 3'd0;
         dead_cnt <= 8'd0;
         pulse_q  <= 1'b0;
         hi_q     <= 3'b000;
         lo_q     <= 3'b000;
      end else if (state_nx == ST_IDLE) begin
         step_cnt <= 25'd0;
         step_idx <= 3'd0;
         dead_cnt <= 8'd0;
         pulse_q  <= 1'b0;
         hi_q     <= 3'b000;
         lo_q     <= 3'b000;
      end else if (entering) begin
         step_cnt <= 25'd0;
         step_idx <= 3'd0;
         dead_cnt <= DEAD_LD;
         pulse_q  <= 1'b0;
         hi_q     <= 3'b000;
         lo_q     <= 3'b000;
      end else if (wrap) begin
         step_cnt <= 25'd0;
         step_idx <= (step_idx == 3'd5) ? 3'd0 : step_idx + 3'd1;
         dead_cnt <= DEAD_LD;
         pulse_q  <= 1'b1;
         hi_q     <= 3'b000;
         lo_q     <= 3'b000;
      end else begin
         step_cnt <= step_cnt + 25'd1;
         dead_cnt <= dead_nx;
         pulse_q  <= 1'b0;
         if (dead_nx == 8'd0) begin
            hi_q <= hi_pat & {3{pwm_gate}};
            lo_q <= lo_pat;
         end else begin
            hi_q <= 3'b000;
            lo_q <= 3'b000;
         end
      end
   end

   motoro3_pwmgen u_pwm (
      .clk      (clk),
      .nRst     (nRst),
      .run      (active),
      .restart  (pwm_restart),
      .pwm_len  (m3r_pwmLenWant),
      .pct      (m3r_power_percent),
      .min_mask (m3r_pwmMinMask),
      .gate     (pwm_gate)
   );

   assign m3c_hiOn      = hi_q;
   assign m3c_loOn      = lo_q;
   assign m3c_stepIdx   = step_idx;
   assign m3c_stepPulse = pulse_q;
   assign m3c_running   = active;

endmodule

// File: tb/tb_motoro3_commutator.sv
// Directed bench for motoro3_commutator with a shortened start period.
module tb_motoro3_commutator;
   import motoro3_defs::*;

   logic        clk;
   logic        nRst;
   logic        m3c_enable;
   logic [24:0] m3r_stepCNT_speedSET;
   logic [7:0]  m3r_power_percent;
   logic [11:0] m3r_pwmLenWant;
   logic [11:0] m3r_pwmMinMask;
   logic [2:0]  m3c_hiOn;
   logic [2:0]  m3c_loOn;
   logic [2:0]  m3c_stepIdx;
   logic        m3c_stepPulse;
   logic        m3c_running;

   int ntests = 0;
   int nfail  = 0;
   int cyc    = 0;
   int last_pulse = 0;
   int exp_idx = 0;

   logic [2:0] exp_hi [6] = '{3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100};
   logic [2:0] exp_lo [6] = '{3'b010, 3'b100, 3'b100, 3'b001, 3'b001, 3'b010};
   int ramp_gap [6] = '{1000, 875, 766, 671, 600, 600};
   int ramp_st  [6] = '{1, 1, 1, 2, 2, 2};
   int down_gap [6] = '{700, 613, 537, 470, 412, 400};
   int down_st  [6] = '{1, 1, 1, 1, 2, 2};

   motoro3_commutator #(
      .START_PERIOD (25'd1000),
      .RAMP_SHIFT   (3),
      .DEAD_CLK     (8)
   ) dut (
      .clk                  (clk),
      .nRst                 (nRst),
      .m3c_enable           (m3c_enable),
      .m3r_stepCNT_speedSET (m3r_stepCNT_speedSET),
      .m3r_power_percent    (m3r_power_percent),
      .m3r_pwmLenWant       (m3r_pwmLenWant),
      .m3r_pwmMinMask       (m3r_pwmMinMask),
      .m3c_hiOn             (m3c_hiOn),
      .m3c_loOn             (m3c_loOn),
      .m3c_stepIdx          (m3c_stepIdx),
      .m3c_stepPulse        (m3c_stepPulse),
      .m3c_running          (m3c_running)
   );

   initial clk = 1'b0;
   always #50 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Waits for the next step pulse, counting active hi/lo clocks on the way.
   task automatic wait_pulse(output int gap, output int hi_n, output int lo_n);
      bit got;
      got  = 1'b0;
      hi_n = 0;
      lo_n = 0;
      for (int n = 0; n < 5000; n++) begin
         @(negedge clk);
         if (m3c_stepPulse) begin
            got = 1'b1;
            break;
         end
         if (|m3c_hiOn) hi_n++;
         if (|m3c_loOn) lo_n++;
      end
      chk("pulse_seen", {31'd0, got}, 32'd1);
      gap = cyc - last_pulse;
      last_pulse = cyc;
      exp_idx = (exp_idx + 1) % 6;
      chk("step_idx", {29'd0, m3c_stepIdx}, exp_idx);
   endtask

   initial begin
      int g, h, l, w;
      bit found;
      nRst = 1'b0;
      m3c_enable = 1'b0;
      m3r_stepCNT_speedSET = 25'd600;
      m3r_power_percent = 8'd255;
      m3r_pwmLenWant = 12'd512;
      m3r_pwmMinMask = 12'd32;
      repeat (3) @(negedge clk);
      chk("rst_hi", {29'd0, m3c_hiOn}, 0);
      chk("rst_lo", {29'd0, m3c_loOn}, 0);
      chk("rst_idx", {29'd0, m3c_stepIdx}, 0);
      chk("rst_pulse", {31'd0, m3c_stepPulse}, 0);
      chk("rst_running", {31'd0, m3c_running}, 0);
      nRst = 1'b1;
      @(negedge clk);

      // start-up, dead time before first drive, ramp 1000 -> 600
      m3c_enable = 1'b1;
      last_pulse = cyc + 1;
      exp_idx = 0;
      @(negedge clk);
      chk("en_running", {31'd0, m3c_running}, 1);
      chk("en_hi_off", {29'd0, m3c_hiOn}, 0);
      repeat (7) @(negedge clk);
      chk("dead7_hi", {29'd0, m3c_hiOn}, 0);
      chk("dead7_lo", {29'd0, m3c_loOn}, 0);
      @(negedge clk);
      chk("first_hi", {29'd0, m3c_hiOn}, 3'b001);
      chk("first_lo", {29'd0, m3c_loOn}, 3'b010);
      for (int k = 0; k < 6; k++) begin
         wait_pulse(g, h, l);
         chk("ramp_gap", g, ramp_gap[k]);
         chk("ramp_state", 32'(dut.state), ramp_st[k]);
      end

      // 12-step commutation sequence at 600
      for (int s = 0; s < 12; s++) begin
         wait_pulse(g, h, l);
         chk("seq_gap", g, 600);
         chk("seq_dead_hi", {29'd0, m3c_hiOn}, 0);
         chk("seq_dead_lo", {29'd0, m3c_loOn}, 0);
         repeat (8) @(negedge clk);
         chk("seq_hi", {29'd0, m3c_hiOn}, exp_hi[exp_idx]);
         chk("seq_lo", {29'd0, m3c_loOn}, exp_lo[exp_idx]);
         chk("seq_overlap", {29'd0, m3c_hiOn & m3c_loOn}, 0);
      end

      // target change 600 -> 800 in RUN, then 800 -> 400 re-ramp
      m3r_stepCNT_speedSET = 25'd800;
      wait_pulse(g, h, l);
      chk("t800_cur_gap", g, 600);
      wait_pulse(g, h, l);
      chk("t800_gap", g, 800);
      chk("t800_state", 32'(dut.state), ST_RUN);
      m3r_stepCNT_speedSET = 25'd400;
      wait_pulse(g, h, l);
      chk("t400_cur_gap", g, 800);
      chk("t400_state", 32'(dut.state), ST_RAMP);
      for (int k = 0; k < 6; k++) begin
         wait_pulse(g, h, l);
         chk("down_gap", g, down_gap[k]);
         chk("down_state", 32'(dut.state), down_st[k]);
      end

      // PWM arithmetic on 2000-clk steps, P=512, minMask=32
      m3r_stepCNT_speedSET = 25'd2000;
      wait_pulse(g, h, l);
      chk("t2000_cur_gap", g, 400);
      wait_pulse(g, h, l);
      chk("pct255_gap", g, 2000);
      chk("pct255_hi", h, 1992);
      chk("pct255_lo", l, 1992);
      m3r_power_percent = 8'd16;
      wait_pulse(g, h, l);
      repeat (8) @(negedge clk);
      found = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (m3c_hiOn == 3'b000) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("pct16_low_seen", {31'd0, found}, 1);
      found = 1'b0;
      for (int n = 0; n < 600; n++) begin
         if (m3c_hiOn != 3'b000) begin found = 1'b1; break; end
         @(negedge clk);
      end
      chk("pct16_rise_seen", {31'd0, found}, 1);
      w = 0;
      while ((m3c_hiOn != 3'b000) && (w < 1000)) begin
         w++;
         @(negedge clk);
      end
      chk("pct16_width", w, 32);
      wait_pulse(g, h, l);
      chk("pct16_gap", g, 2000);
      m3r_power_percent = 8'd15;
      wait_pulse(g, h, l);
      wait_pulse(g, h, l);
      chk("pct15_hi", h, 0);
      chk("pct15_lo", l, 1992);
      m3r_power_percent = 8'd255;
      wait_pulse(g, h, l);

      // disable mid-step, then re-enable with edge inputs
      repeat (100) @(negedge clk);
      chk("pre_dis_hi", {29'd0, m3c_hiOn}, exp_hi[exp_idx]);
      m3c_enable = 1'b0;
      @(negedge clk);
      chk("dis_hi", {29'd0, m3c_hiOn}, 0);
      chk("dis_lo", {29'd0, m3c_loOn}, 0);
      chk("dis_idx", {29'd0, m3c_stepIdx}, 0);
      chk("dis_running", {31'd0, m3c_running}, 0);
      m3r_stepCNT_speedSET = 25'd10;
      m3r_power_percent = 8'd128;
      m3r_pwmLenWant = 12'd0;
      m3r_pwmMinMask = 12'd0;
      repeat (2) @(negedge clk);
      m3c_enable = 1'b1;
      last_pulse = cyc + 1;
      exp_idx = 0;
      @(negedge clk);
      chk("reen_idx", {29'd0, m3c_stepIdx}, 0);
      chk("reen_running", {31'd0, m3c_running}, 1);
      wait_pulse(g, h, l);
      chk("reen_gap", g, 1000);
      for (int k = 0; k < 40; k++) begin
         if (dut.state == ST_RUN) break;
         wait_pulse(g, h, l);
      end
      chk("min_state", 32'(dut.state), ST_RUN);
      wait_pulse(g, h, l);
      chk("min_gap", g, 64);
      chk("p2_hi", h, 28);
      chk("p2_lo", l, 56);

      // async reset inside the dead time
      repeat (3) @(negedge clk);
      #10 nRst = 1'b0;
      #1;
      chk("arst_idx", {29'd0, m3c_stepIdx}, 0);
      chk("arst_running", {31'd0, m3c_running}, 0);
      chk("arst_hi", {29'd0, m3c_hiOn}, 0);
      chk("arst_lo", {29'd0, m3c_loOn}, 0);
      chk("arst_pulse", {31'd0, m3c_stepPulse}, 0);
      #20 nRst = 1'b1;
      m3c_enable = 1'b0;
      repeat (2) @(negedge clk);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule

// File: doc/motoro3_commutator.md
# motoro3_commutator

Six-step commutation and PWM sequencer for the 3-phase motor drive. Consumes the static settings from the motor register block (step period, power percent, PWM length, minimum on-time) and produces gate-enable signals for the three half-bridges. It soft-starts the step rate from a slow start period down to the requested period, inserts dead time at every commutation, and suppresses PWM pulses too short for the MOS drivers.

## Interface
- START_PERIOD, 25'd1_666_667: step period (clk cycles) at spin-up.
- RAMP_SHIFT, 4: per-step period reduction during ramp is `curPeriod >> RAMP_SHIFT`.
- DEAD_CLK, 8: all-off clocks inserted at each step boundary.
- MIN_PERIOD, 25'd64: floor applied to the step-period input.
- clk  in  1  system clock, 10 MHz.
- nRst  in  1  asynchronous, active-low reset.
- m3c_enable  in  1  run request (level).
- m3r_stepCNT_speedSET  in  25  target step period in clks.
- m3r_power_percent  in  8  duty scale, on-time = pwmLen·pct/256.
- m3r_pwmLenWant  in  12  PWM period in clks.
- m3r_pwmMinMask  in  12  minimum usable on/off time in clks.
- m3c_hiOn  out  3  high-side enables {C,B,A}.
- m3c_loOn  out  3  low-side enables {C,B,A}.
- m3c_stepIdx  out  3  current step, 0..5.
- m3c_stepPulse  out  1  one-clk pulse at each step boundary.
- m3c_running  out  1  high in RAMP or RUN.

## Operation
- Reset: every output 0, FSM IDLE, curPeriod = START_PERIOD, all counters 0.
- States: IDLE → RAMP (enable=1) → RUN (curPeriod == target) → IDLE (enable=0, from any state).
- target = max(m3r_stepCNT_speedSET, MIN_PERIOD), sampled only at step boundaries.
- Entering RAMP: curPeriod = max(START_PERIOD, target), stepIdx = 0.
- Step counter counts curPeriod clks per step, then wraps. At wrap: stepPulse, stepIdx advances 5→0, dead-time counter loads DEAD_CLK.
- RAMP at each boundary: next = curPeriod − (curPeriod >> RAMP_SHIFT), clamped to ≥ target. RAMP → RUN when the result equals target.
- RUN at each boundary: if target < curPeriod, go to RAMP (re-ramp from curPeriod). If target ≥ curPeriod, curPeriod = target immediately.
- Commutation (hi/lo): step0 A/B, 1 A/C, 2 B/C, 3 B/A, 4 C/A, 5 C/B. The low side is held on for the whole step. The high side is gated by PWM.
- PWM: period P = max(pwmLenWant, 2). Raw on-time = (P × power_percent) >> 8, 20-bit product.
  - raw < pwmMinMask → on = 0.
  - raw > P − pwmMinMask → on = P (full-on).
  - else on = raw.
  - Inputs are sampled at each PWM period start. High side is on while pwmCnt < on.
- PWM counter free-runs in RAMP/RUN and restarts at 0 on entry to RAMP.

## Timing
- hiOn/loOn/stepIdx are registered outputs.
- enable rise at cycle N: running=1 at N+1. The first drive pattern appears at N+1+DEAD_CLK.
- enable fall at cycle N: all outputs 0 at N+1. This holds mid-step and mid-dead-time.
- Dead time counts inside the step: step length stays exactly curPeriod clks, and the drive pattern is active for curPeriod − DEAD_CLK clks.
- Consecutive stepPulses are exactly curPeriod clks apart.
- A target change takes effect at the next boundary, never mid-step.
- Async reset mid-step forces all outputs to 0 immediately.

## Structure
- Shared package/header `motoro3_defs`: state encodings, the 6-entry commutation table, MIN_PERIOD.
- One sub-module, `motoro3_pwmgen`: PWM counter, on-time arithmetic, min-mask saturation. It outputs a single gate bit.
- The top holds the FSM, step counter, dead-time counter and ramp arithmetic.

## Test plan
- Ramp: START_PERIOD=1000, RAMP_SHIFT=3, target=600 → boundary spacing 1000, 875, 766, 671, then 600 with RUN. Spacing stays 600.
- Sequence: run 12 steps → stepIdx 0..5,0..5. hi/lo match the table. Each step shows DEAD_CLK all-off clks, and hi and lo are never on in the same phase.
- PWM arithmetic, P=512, minMask=32:
  - pct=16 → 32-clk pulses.
  - pct=15 → no high-side pulses.
  - pct=255 → high side continuously on.
- Target change in RUN: 600→800 → next spacing is 800, no RAMP. Then 800→400 → RAMP state, 700, 613, 537, … clamped at 400.
- Disable mid-step at cycle N → all outputs 0 at N+1. Re-enable → restarts at stepIdx 0 with START_PERIOD.
- Edge inputs: speedSET=10 → period 64. pwmLenWant=0 → P=2. nRst asserted mid-dead-time → all outputs 0 asynchronously.
